cpu_gen2: RTL and testbench



---
 rtl/cpu_gen2_pkg.sv | 35 +++
 rtl/cpu_gen2_stack.sv | 46 ++++
 rtl/cpu_gen2.sv | 112 +++++++++++
 tb/tb_cpu_gen2.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_gen2_pkg.sv
// Shared opcode constants and instruction field helpers for the cpu_gen2 core.
package cpu_gen2_pkg;

    localparam int unsigned OPCODE_W   = 4;
    localparam int unsigned MAX_INST_W = 64;

    localparam logic [OPCODE_W-1:0] OP_ADD_A  = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_MOV_AB = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_IN_A   = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_MOV_AI = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_MOV_BA = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_ADD_B  = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_IN_B   = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_MOV_BI = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_CALL   = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_OUT_B  = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_RET    = 4'hA;
    localparam logic [OPCODE_W-1:0] OP_OUT_I  = 4'hB;
    localparam logic [OPCODE_W-1:0] OP_HALT   = 4'hC;
    localparam logic [OPCODE_W-1:0] OP_JC     = 4'hD;
    localparam logic [OPCODE_W-1:0] OP_JNC    = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_JMP    = 4'hF;

    // Callers zero-extend inst to MAX_INST_W so one helper serves every DATA_W.
    function automatic logic [OPCODE_W-1:0] inst_opcode(input logic [MAX_INST_W-1:0] i,
                                                         input int unsigned data_w);
        return OPCODE_W'(i >> data_w);
    endfunction

    function automatic logic [MAX_INST_W-1:0] inst_imm(input logic [MAX_INST_W-1:0] i,
                                                       input int unsigned data_w);
        return i & ((MAX_INST_W'(1) << data_w) - MAX_INST_W'(1));
    endfunction

endpackage

// File: rtl/cpu_gen2_stack.sv
// Return-address LIFO for cpu_gen2; storage is not reset, only the stack pointer.
module cpu_gen2_stack
    import cpu_gen2_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [DATA_W-1:0]                  din,
    output logic [DATA_W-1:0]                  top,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [DATA_W-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q;

    assign full  = (sp_q == SP_W'(STACK_DEPTH));
    assign empty = (sp_q == '0);
    assign sp    = sp_q;
    assign top   = mem[IDX_W'(sp_q - SP_W'(1))];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[IDX_W'(sp_q)] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sp_q <= '0;
        end else if (push) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

endmodule

// File: rtl/cpu_gen2.sv
// Parametrised TD4-style core with fetch handshake, CALL/RET stack, JC and HALT.
// Defining CPU_GEN2_DBG_PORT_EN exposes reg A, reg B and the stack pointer as outputs.
module cpu_gen2
    import cpu_gen2_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                    clk_cpu,
    input  logic                    reset,
    input  logic [DATA_W+3:0]       inst,
    input  logic                    inst_valid,
    input  logic [DATA_W-1:0]       in_port,
    output logic [DATA_W-1:0]       pc,
    output logic [DATA_W-1:0]       out_port,
    output logic                    carry,
    output logic                    halted,
    output logic                    stack_err
`ifdef CPU_GEN2_DBG_PORT_EN
    ,
    output logic [DATA_W-1:0]                dbg_reg_a,
    output logic [DATA_W-1:0]                dbg_reg_b,
    output logic [$clog2(STACK_DEPTH+1)-1:0] dbg_sp
`endif
);

    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    logic [DATA_W-1:0] pc_q, a_q, b_q, out_q;
    logic              carry_q, halted_q, stack_err_q;

    logic [OPCODE_W-1:0] opcode;
    logic [DATA_W-1:0]   imm, add_op, pc_inc, stack_top;
    logic [DATA_W:0]     add_res;
    logic                exec, push, pop, stack_full, stack_empty;
    logic [SP_W-1:0]     stack_sp;

    assign opcode  = inst_opcode(MAX_INST_W'(inst), DATA_W);
    assign imm     = DATA_W'(inst_imm(MAX_INST_W'(inst), DATA_W));
    assign exec    = inst_valid && !halted_q;
    assign add_op  = (opcode == OP_ADD_B) ? b_q : a_q;
    assign add_res = {1'b0, add_op} + {1'b0, imm};
    assign pc_inc  = pc_q + DATA_W'(1);
    assign push    = exec && (opcode == OP_CALL) && !stack_full;
    assign pop     = exec && (opcode == OP_RET) && !stack_empty;

    cpu_gen2_stack #(
        .DATA_W      (DATA_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk_cpu),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (stack_top),
        .full  (stack_full),
        .empty (stack_empty),
        .sp    (stack_sp)
    );

    always_ff @(posedge clk_cpu) begin
        if (!reset) begin
            pc_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            carry_q     <= 1'b0;
            halted_q    <= 1'b0;
            stack_err_q <= 1'b0;
        end else if (exec) begin
            // Only ADD sets carry; every other executed instruction clears it.
            carry_q <= 1'b0;
            pc_q    <= pc_inc;
            case (opcode)
                OP_ADD_A:  begin a_q <= add_res[DATA_W-1:0]; carry_q <= add_res[DATA_W]; end
                OP_MOV_AB: a_q <= b_q;
                OP_IN_A:   a_q <= in_port;
                OP_MOV_AI: a_q <= imm;
                OP_MOV_BA: b_q <= a_q;
                OP_ADD_B:  begin b_q <= add_res[DATA_W-1:0]; carry_q <= add_res[DATA_W]; end
                OP_IN_B:   b_q <= in_port;
                OP_MOV_BI: b_q <= imm;
                OP_CALL:   if (stack_full) stack_err_q <= 1'b1; else pc_q <= imm;
                OP_OUT_B:  out_q <= b_q;
                OP_RET:    if (stack_empty) stack_err_q <= 1'b1; else pc_q <= stack_top;
                OP_OUT_I:  out_q <= imm;
                OP_HALT:   begin halted_q <= 1'b1; pc_q <= pc_q; end
                OP_JC:     if (carry_q) pc_q <= imm;
                OP_JNC:    if (!carry_q) pc_q <= imm;
                OP_JMP:    pc_q <= imm;
                default:   ;
            endcase
        end
    end

    assign pc        = pc_q;
    assign out_port  = out_q;
    assign carry     = carry_q;
    assign halted    = halted_q;
    assign stack_err = stack_err_q;

`ifdef CPU_GEN2_DBG_PORT_EN
    assign dbg_reg_a = a_q;
    assign dbg_reg_b = b_q;
    assign dbg_sp    = stack_sp;
`else
    logic unused_stack_sp;
    assign unused_stack_sp = ^stack_sp;
`endif

endmodule

// File: tb/tb_cpu_gen2.sv
// Directed self-checking bench for cpu_gen2 (DATA_W=4, STACK_DEPTH=4).
module tb_cpu_gen2;

    localparam int unsigned DATA_W      = 4;
    localparam int unsigned STACK_DEPTH = 4;

    logic       clk_cpu = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] inst = 8'h00;
    logic       inst_valid = 1'b0;
    logic [3:0] in_port = 4'h0;
    logic [3:0] pc, out_port;
    logic       carry, halted, stack_err;
    logic [3:0] obs_a, obs_b;
    logic [2:0] obs_sp;

    int tests = 0;
    int fails = 0;

    always #5 clk_cpu = ~clk_cpu;

`ifdef CPU_GEN2_DBG_PORT_EN
    cpu_gen2 #(.DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk_cpu(clk_cpu), .reset(reset), .inst(inst), .inst_valid(inst_valid),
        .in_port(in_port), .pc(pc), .out_port(out_port), .carry(carry), .halted(halted),
        .stack_err(stack_err), .dbg_reg_a(obs_a), .dbg_reg_b(obs_b), .dbg_sp(obs_sp)
    );
`else
    cpu_gen2 #(.DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk_cpu(clk_cpu), .reset(reset), .inst(inst), .inst_valid(inst_valid),
        .in_port(in_port), .pc(pc), .out_port(out_port), .carry(carry), .halted(halted),
        .stack_err(stack_err)
    );
    assign obs_a  = dut.a_q;
    assign obs_b  = dut.b_q;
    assign obs_sp = dut.u_stack.sp_q;
`endif

    // Drive one instruction for one edge, then settle past the edge before checks.
    task automatic exec(input logic [7:0] i);
        reset      = 1'b1;
        inst       = i;
        inst_valid = 1'b1;
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        inst_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            inst = 8'($urandom_range(0, 255));
            @(posedge clk_cpu);
            #1;
        end
        tests++; if (pc !== 4'h0) begin fails++; $display("FAIL reset_pc got %0h want 0", pc); end
        tests++; if (obs_a !== 4'h0) begin fails++; $display("FAIL reset_a got %0h want 0", obs_a); end
        tests++; if (obs_b !== 4'h0) begin fails++; $display("FAIL reset_b got %0h want 0", obs_b); end
        tests++; if (out_port !== 4'h0) begin fails++; $display("FAIL reset_out got %0h want 0", out_port); end
        tests++; if (carry !== 1'b0) begin fails++; $display("FAIL reset_carry got %0b want 0", carry); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %0b want 0", halted); end
        tests++; if (stack_err !== 1'b0) begin fails++; $display("FAIL reset_err got %0b want 0", stack_err); end
    endtask

    task automatic test_add_jnc();
        exec(8'h33);
        tests++; if (obs_a !== 4'h3) begin fails++; $display("FAIL mov_a_imm got %0h want 3", obs_a); end
        exec(8'h0E);
        tests++; if (obs_a !== 4'h1) begin fails++; $display("FAIL add_a_sum got %0h want 1", obs_a); end
        tests++; if (carry !== 1'b1) begin fails++; $display("FAIL add_a_carry got %0b want 1", carry); end
        exec(8'hE5);
        tests++; if (pc !== 4'h3) begin fails++; $display("FAIL jnc_not_taken_pc got %0h want 3", pc); end
        tests++; if (carry !== 1'b0) begin fails++; $display("FAIL jnc_clears_carry got %0b want 0", carry); end
        exec(8'hE5);
        tests++; if (pc !== 4'h5) begin fails++; $display("FAIL jnc_taken_pc got %0h want 5", pc); end
    endtask

    task automatic test_wrap_stall();
        exec(8'hFF);
        tests++; if (pc !== 4'hF) begin fails++; $display("FAIL jmp_pc got %0h want f", pc); end
        exec(8'h77);
        tests++; if (pc !== 4'h0) begin fails++; $display("FAIL pc_wrap got %0h want 0", pc); end
        tests++; if (obs_b !== 4'h7) begin fails++; $display("FAIL mov_b_imm got %0h want 7", obs_b); end
        exec(8'h90);
        tests++; if (out_port !== 4'h7) begin fails++; $display("FAIL out_b got %0h want 7", out_port); end
        exec(8'h0F);
        tests++; if (obs_a !== 4'h0 || carry !== 1'b1) begin
            fails++; $display("FAIL add_wrap got a=%0h c=%0b want a=0 c=1", obs_a, carry);
        end
        inst_valid = 1'b0;
        inst       = 8'h0F;
        repeat (3) @(posedge clk_cpu);
        #1;
        tests++; if (pc !== 4'h2 || obs_a !== 4'h0 || obs_b !== 4'h7 || carry !== 1'b1) begin
            fails++;
            $display("FAIL stall got pc=%0h a=%0h b=%0h c=%0b want pc=2 a=0 b=7 c=1",
                     pc, obs_a, obs_b, carry);
        end
    endtask

    task automatic test_call_ret();
        exec(8'h88);
        tests++; if (pc !== 4'h8 || obs_sp !== 3'd1) begin
            fails++; $display("FAIL call got pc=%0h sp=%0d want pc=8 sp=1", pc, obs_sp);
        end
        in_port = 4'h9;
        exec(8'h20);
        tests++; if (obs_a !== 4'h9) begin fails++; $display("FAIL in_a got %0h want 9", obs_a); end
        exec(8'hA0);
        tests++; if (pc !== 4'h3 || stack_err !== 1'b0 || obs_sp !== 3'd0) begin
            fails++;
            $display("FAIL ret got pc=%0h err=%0b sp=%0d want pc=3 err=0 sp=0", pc, stack_err, obs_sp);
        end
    endtask

    task automatic test_stack_limits();
        exec(8'h84);
        exec(8'h85);
        exec(8'h86);
        exec(8'h87);
        tests++; if (pc !== 4'h7 || obs_sp !== 3'd4 || stack_err !== 1'b0) begin
            fails++;
            $display("FAIL call4 got pc=%0h sp=%0d err=%0b want pc=7 sp=4 err=0", pc, obs_sp, stack_err);
        end
        exec(8'h80);
        tests++; if (pc !== 4'h8 || obs_sp !== 3'd4 || stack_err !== 1'b1) begin
            fails++;
            $display("FAIL overflow got pc=%0h sp=%0d err=%0b want pc=8 sp=4 err=1", pc, obs_sp, stack_err);
        end
        exec(8'hA0);
        tests++; if (pc !== 4'h7 || obs_sp !== 3'd3 || stack_err !== 1'b1) begin
            fails++;
            $display("FAIL lifo_top got pc=%0h sp=%0d err=%0b want pc=7 sp=3 err=1", pc, obs_sp, stack_err);
        end
        reset = 1'b0;
        inst  = 8'hF9;
        @(posedge clk_cpu);
        #1;
        tests++; if (pc !== 4'h0 || obs_sp !== 3'd0 || stack_err !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got pc=%0h sp=%0d err=%0b want pc=0 sp=0 err=0", pc, obs_sp, stack_err);
        end
        exec(8'hA0);
        tests++; if (pc !== 4'h1 || stack_err !== 1'b1 || obs_sp !== 3'd0) begin
            fails++;
            $display("FAIL underflow got pc=%0h err=%0b sp=%0d want pc=1 err=1 sp=0", pc, stack_err, obs_sp);
        end
    endtask

    task automatic test_jc_halt();
        exec(8'h3F);
        exec(8'h01);
        tests++; if (carry !== 1'b1 || pc !== 4'h3) begin
            fails++; $display("FAIL pre_jc got c=%0b pc=%0h want c=1 pc=3", carry, pc);
        end
        exec(8'hD9);
        tests++; if (pc !== 4'h9 || carry !== 1'b0) begin
            fails++; $display("FAIL jc_taken got pc=%0h c=%0b want pc=9 c=0", pc, carry);
        end
        exec(8'hBA);
        tests++; if (out_port !== 4'hA) begin fails++; $display("FAIL out_imm got %0h want a", out_port); end
        exec(8'h3F);
        exec(8'hF3);
        exec(8'h01);
        exec(8'hC0);
        tests++; if (halted !== 1'b1 || pc !== 4'h4 || carry !== 1'b0) begin
            fails++;
            $display("FAIL halt got h=%0b pc=%0h c=%0b want h=1 pc=4 c=0", halted, pc, carry);
        end
        exec(8'hB5);
        tests++; if (out_port !== 4'hA || pc !== 4'h4 || halted !== 1'b1) begin
            fails++;
            $display("FAIL halted_ignore got out=%0h pc=%0h h=%0b want out=a pc=4 h=1",
                     out_port, pc, halted);
        end
        reset = 1'b0;
        @(posedge clk_cpu);
        #1;
        tests++; if (halted !== 1'b0 || pc !== 4'h0 || out_port !== 4'h0) begin
            fails++;
            $display("FAIL halt_reset got h=%0b pc=%0h out=%0h want h=0 pc=0 out=0",
                     halted, pc, out_port);
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add_jnc();
        test_wrap_stall();
        test_call_ret();
        test_stack_limits();
        test_jc_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
